// File: rtl/tsc_rx.sv
// ---------------------------------------------------------------------------
// tsc_rx - host-side receiver for the transient-signal-capture serial dump.
//
// Requests a buffer dump from the capture block with a one-cycle SBF pulse,
// then deserialises the returned 8N1 byte frames arriving on SD into a local
// sample memory that the host can read at any time.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   dump        host request pulse, accepted only when idle
//   SBF         send-buffer request pulse toward the capture block
//   SD          serial data from the capture block, idles high
//   rd_addr     host read address
//   rd_data     mem[rd_addr], one-cycle registered read
//   byte_count  bytes stored in the current/last dump
//   busy        dump in progress
//   done        one-cycle pulse at the end of a dump (normal or timeout)
//   frame_err   sticky, a stop bit was sampled low during this dump
//   timeout     sticky, this dump was aborted waiting for a start bit
// ---------------------------------------------------------------------------
// state      | meaning
// S_IDLE     | waiting for a host dump request
// S_REQ      | driving the SBF pulse
// S_WAIT     | line idle, looking for a start bit, timeout counter running
// S_START    | waiting until mid start bit to confirm it is not a glitch
// S_DATA     | sampling 8 data bits, LSB first, one per bit period
// S_STOP     | sampling the stop bit, storing or discarding the byte
// S_DONE     | done pulse, then back to idle
// ---------------------------------------------------------------------------
module tsc_rx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DEPTH        = 32,
   parameter int TIMEOUT      = 4096,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dump,
   output logic          SBF,
   input  logic          SD,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [AW:0]   byte_count,
   output logic          busy,
   output logic          done,
   output logic          frame_err,
   output logic          timeout
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]    state_q, state_d;
   logic          sd_meta_q, sd_sync_q;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   cnt_inc;
   logic          ferr_q, ferr_d;
   logic          tmo_flag_q, tmo_flag_d;
   logic          mem_we;
   logic [7:0]    rd_data_q;
   logic [7:0]    mem [DEPTH];

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tmo_d      = tmo_q;
      cnt_d      = cnt_q;
      ferr_d     = ferr_q;
      tmo_flag_d = tmo_flag_q;
      mem_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dump) begin
               state_d    = S_REQ;
               cnt_d      = '0;
               ferr_d     = 1'b0;
               tmo_flag_d = 1'b0;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
            tmo_d   = '0;
         end
         S_WAIT: begin
            if (!sd_sync_q) begin
               state_d = S_START;
               baud_d  = BAUD_HALF;
            end else if (tmo_q == TMO_LAST) begin
               tmo_flag_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_START: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else if (!sd_sync_q) begin
               state_d = S_DATA;
               baud_d  = BAUD_FULL;
               bit_d   = 3'd0;
            end else begin
               // Start bit vanished before mid-bit: treat as a glitch and keep
               // the idle timeout running from where it was.
               state_d = S_WAIT;
            end
         end
         S_DATA: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else begin
               shift_d = {sd_sync_q, shift_q[7:1]};
               baud_d  = BAUD_FULL;
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else begin
               tmo_d = '0;
               // cnt_q is always below DEPTH here: reaching DEPTH exits to
               // S_DONE, so the count saturates without wrapping.
               if (sd_sync_q) begin
                  mem_we  = 1'b1;
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == CNT_FULL) ? S_DONE : S_WAIT;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = (cnt_q == CNT_FULL) ? S_DONE : S_WAIT;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sd_meta_q  <= 1'b1;
         sd_sync_q  <= 1'b1;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tmo_q      <= '0;
         cnt_q      <= '0;
         ferr_q     <= 1'b0;
         tmo_flag_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         sd_meta_q  <= SD;
         sd_sync_q  <= sd_meta_q;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tmo_q      <= tmo_d;
         cnt_q      <= cnt_d;
         ferr_q     <= ferr_d;
         tmo_flag_q <= tmo_flag_d;
         rd_data_q  <= mem[rd_addr];
      end
   end

   // Memory is deliberately not reset; a reset in the stop-bit sample cycle
   // must not commit the byte.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[cnt_q[AW-1:0]] <= shift_d;
      end
   end

   assign SBF        = (state_q == S_REQ);
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign rd_data    = rd_data_q;
   assign byte_count = cnt_q;
   assign frame_err  = ferr_q;
   assign timeout    = tmo_flag_q;

endmodule

// File: tb/tb_tsc_rx.sv
module tb_tsc_rx;
   localparam int CPB   = 8;
   localparam int DEPTH = 32;
   localparam int TMO   = 4096;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          dump = 1'b0;
   logic          SD = 1'b1;
   logic [AW-1:0] rd_addr = '0;
   logic          SBF;
   logic [7:0]    rd_data;
   logic [AW:0]   byte_count;
   logic          busy, done, frame_err, timeout;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int sbf_cnt = 0;

   tsc_rx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .dump(dump), .SBF(SBF), .SD(SD),
      .rd_addr(rd_addr), .rd_data(rd_data), .byte_count(byte_count),
      .busy(busy), .done(done), .frame_err(frame_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (SBF === 1'b1) sbf_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      SD = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         SD = b[i];
         tick(CPB);
      end
      SD = stop_bit;
      tick(CPB);
      SD = 1'b1;
   endtask

   task automatic pulse_dump();
      dump = 1'b1;
      tick(1);
      dump = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      n_cmp++; if (SBF !== 1'b0) begin n_err++; $display("FAIL reset_sbf: got %b want 0", SBF); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      n_cmp++; if (byte_count !== 6'd0) begin n_err++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
      reset = 1'b0;
      tick(100);
      n_cmp++; if (sbf_cnt !== 0) begin n_err++; $display("FAIL idle_sbf_count: got %0d want 0", sbf_cnt); end
      n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL idle_done_count: got %0d want 0", done_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_full_dump();
      int s0, d0, k;
      s0 = sbf_cnt;
      d0 = done_cnt;
      pulse_dump();
      n_cmp++; if (SBF !== 1'b1) begin n_err++; $display("FAIL full_sbf_pulse: got %b want 1", SBF); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy); end
      tick(1);
      n_cmp++; if (SBF !== 1'b0) begin n_err++; $display("FAIL full_sbf_width: got %b want 0", SBF); end
      tick(3);
      for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1);
      for (k = 0; k < 100 && busy; k++) tick(1);
      tick(1);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_end_busy: got %b want 0", busy); end
      n_cmp++; if (byte_count !== 6'd32) begin n_err++; $display("FAIL full_byte_count: got %0d want 32", byte_count); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL full_frame_err: got %b want 0", frame_err); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL full_timeout: got %b want 0", timeout); end
      n_cmp++; if (sbf_cnt - s0 !== 1) begin n_err++; $display("FAIL full_sbf_count: got %0d want 1", sbf_cnt - s0); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); end
      rd_addr = 5'd5;
      tick(1);
      n_cmp++; if (rd_data !== 8'h05) begin n_err++; $display("FAIL full_rd5: got %h want 05", rd_data); end
      rd_addr = 5'd31;
      tick(1);
      n_cmp++; if (rd_data !== 8'h1f) begin n_err++; $display("FAIL full_rd31: got %h want 1f", rd_data); end
   endtask

   task automatic test_frame_err();
      int d0, k;
      logic [7:0] b;
      d0 = done_cnt;
      pulse_dump();
      tick(4);
      for (int i = 0; i < DEPTH; i++) begin
         b = (i == 3) ? 8'hA5 : 8'(i);
         send_frame(b, (i == 3) ? 1'b0 : 1'b1);
      end
      n_cmp++; if (byte_count !== 6'd31) begin n_err++; $display("FAIL ferr_byte_count: got %0d want 31", byte_count); end
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_waiting: got %b want 1", busy); end
      for (k = 0; k < TMO + 200 && busy; k++) tick(1);
      tick(1);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_end_busy: got %b want 0", busy); end
      n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL ferr_timeout: got %b want 1", timeout); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL ferr_done_count: got %0d want 1", done_cnt - d0); end
      rd_addr = 5'd2;
      tick(1);
      n_cmp++; if (rd_data !== 8'h02) begin n_err++; $display("FAIL ferr_rd2: got %h want 02", rd_data); end
      rd_addr = 5'd3;
      tick(1);
      n_cmp++; if (rd_data !== 8'h04) begin n_err++; $display("FAIL ferr_rd3: got %h want 04", rd_data); end
      rd_addr = 5'd30;
      tick(1);
      n_cmp++; if (rd_data !== 8'h1f) begin n_err++; $display("FAIL ferr_rd30: got %h want 1f", rd_data); end
   endtask

   task automatic test_glitch();
      int k;
      pulse_dump();
      tick(4);
      SD = 1'b0;
      tick(3);
      SD = 1'b1;
      tick(20);
      n_cmp++; if (byte_count !== 6'd0) begin n_err++; $display("FAIL glitch_no_byte: got %0d want 0", byte_count); end
      send_frame(8'hD5, 1'b1);
      tick(2);
      n_cmp++; if (byte_count !== 6'd1) begin n_err++; $display("FAIL glitch_byte_count: got %0d want 1", byte_count); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
      for (k = 0; k < TMO + 200 && busy; k++) tick(1);
      tick(1);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_end_busy: got %b want 0", busy); end
      rd_addr = 5'd0;
      tick(1);
      n_cmp++; if (rd_data !== 8'hD5) begin n_err++; $display("FAIL glitch_rd0: got %h want d5", rd_data); end
   endtask

   task automatic test_timeout();
      int s0, d0;
      s0 = sbf_cnt;
      d0 = done_cnt;
      SD = 1'b1;
      pulse_dump();
      tick(100);
      pulse_dump();
      tick(TMO - 101);
      // One cycle before the abort: still waiting.
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_busy_before: got %b want 1", busy); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_flag_before: got %b want 0", timeout); end
      tick(1);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL tmo_done: got %b want 1", done); end
      n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b want 1", timeout); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_busy: got %b want 0", busy); end
      n_cmp++; if (byte_count !== 6'd0) begin n_err++; $display("FAIL tmo_byte_count: got %0d want 0", byte_count); end
      tick(2);
      n_cmp++; if (sbf_cnt - s0 !== 1) begin n_err++; $display("FAIL tmo_sbf_count: got %0d want 1", sbf_cnt - s0); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL tmo_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int s0, k;
      logic [7:0] b;
      pulse_dump();
      tick(4);
      for (int i = 0; i < 10; i++) send_frame(8'h60 + 8'(i), 1'b1);
      b = 8'h6A;
      rd_addr = 5'd5;
      SD = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         SD = b[i];
         tick(CPB);
      end
      SD = b[4];
      tick(CPB / 2);
      n_cmp++; if (byte_count !== 6'd10) begin n_err++; $display("FAIL mid_pre_count: got %0d want 10", byte_count); end
      n_cmp++; if (rd_data !== 8'h65) begin n_err++; $display("FAIL mid_pre_rd5: got %h want 65", rd_data); end
      reset = 1'b1;
      tick(1);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_cmp++; if (byte_count !== 6'd0) begin n_err++; $display("FAIL mid_byte_count: got %0d want 0", byte_count); end
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL mid_rd_data: got %h want 00", rd_data); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL mid_timeout: got %b want 0", timeout); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", done); end
      // dump together with reset must be dropped.
      s0 = sbf_cnt;
      dump = 1'b1;
      tick(1);
      reset = 1'b0;
      dump = 1'b0;
      SD = 1'b1;
      tick(5);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_dump_with_reset: got busy %b want 0", busy); end
      n_cmp++; if (sbf_cnt - s0 !== 0) begin n_err++; $display("FAIL mid_sbf_with_reset: got %0d want 0", sbf_cnt - s0); end
      rd_addr = 5'd10;
      tick(1);
      n_cmp++; if (rd_data !== 8'h0B) begin n_err++; $display("FAIL mid_no_partial_write: got %h want 0b", rd_data); end
      pulse_dump();
      tick(4);
      for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b1);
      for (k = 0; k < 100 && busy; k++) tick(1);
      tick(1);
      n_cmp++; if (byte_count !== 6'd32) begin n_err++; $display("FAIL mid_redump_count: got %0d want 32", byte_count); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_redump_ferr: got %b want 0", frame_err); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_redump_busy: got %b want 0", busy); end
      rd_addr = 5'd10;
      tick(1);
      n_cmp++; if (rd_data !== 8'h4A) begin n_err++; $display("FAIL mid_redump_rd10: got %h want 4a", rd_data); end
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_frame_err();
      test_glitch();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tsc_rx.md
Name: tsc_rx

Overview:
- Host-side receiver for the transient-signal-capture serial dump.
- Requests a buffer dump by pulsing SBF toward the capture block, then deserialises the returned byte frames on SD.
- Stores the bytes in a local sample memory readable by the host, and reports completion, framing errors and timeout.
- Sits between the capture block's SBF/SD pins and the host readout logic.

Parameters:
CLKS_PER_BIT, 8, clk cycles per serial bit; even, >= 4
DEPTH, 32, bytes expected per dump; power of two
TIMEOUT, 4096, idle-line clk cycles tolerated between frames before abort

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
dump  in  1  host request; one-cycle pulse starts a dump
SBF  out  1  send-buffer request to capture block; one-cycle pulse
SD  in  1  serial data from capture block; idles high
rd_addr  in  log2(DEPTH)  host read address
rd_data  out  8  mem[rd_addr], registered, 1-cycle latency
byte_count  out  log2(DEPTH)+1  bytes stored in current/last dump
busy  out  1  high from dump acceptance until DONE/abort
done  out  1  one-cycle pulse at end of dump (normal or timeout)
frame_err  out  1  sticky: a stop bit was sampled low
timeout  out  1  sticky: dump aborted by TIMEOUT

Behaviour:
- Reset (reset=1 at clk edge): state IDLE; SBF, busy, done, frame_err, timeout = 0; byte_count = 0; rd_data = 0; bit/baud/timeout counters = 0; synchroniser flops = 1. Memory contents are not cleared. Reset mid-frame aborts immediately; no partial byte is written.
- SD passes through a 2-flop synchroniser, initialised to 1. All sampling uses the synchronised value, so an SD edge is visible 2 cycles after it occurs.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1; each bit is CLKS_PER_BIT cycles.
- State machine:
  - IDLE: when dump=1, go to REQ. Clear byte_count, frame_err and timeout; set busy=1.
  - REQ: SBF=1 for exactly this cycle, then go to WAIT_START with the timeout counter at 0.
  - WAIT_START: timeout counter increments each cycle. A synchronised SD=0 goes to START_CHK with the baud counter at 0. If the counter reaches TIMEOUT-1 with no start bit, set timeout=1 and go to DONE.
  - START_CHK: after CLKS_PER_BIT/2 cycles (mid start bit), resample SD.
    - SD=0: go to DATA with bit index 0.
    - SD=1: glitch; return to WAIT_START without resetting the timeout counter.
  - DATA: sample every CLKS_PER_BIT cycles. Shift the sample into bit[index], LSB first. After the 8th sample, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - SD=1: write the byte to mem[byte_count] and increment byte_count.
    - SD=0: set frame_err=1 and discard the byte; byte_count is unchanged.
    - Either case: reset the timeout counter. If byte_count (after any increment) equals DEPTH, go to DONE; otherwise go to WAIT_START.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- A dump pulse is ignored in every state except IDLE. dump and reset in the same cycle: reset wins.
- byte_count saturates at DEPTH and never wraps. Write address is byte_count[log2(DEPTH)-1:0].
- Host reads are allowed at any time. Reading the address being written in the same cycle returns the old data.
- Sampling alignment: first data sample is at CLKS_PER_BIT/2 + CLKS_PER_BIT cycles after the synchronised start edge, which gives ±CLKS_PER_BIT/2 tolerance.

Test Plan:
1. Reset then idle (SD=1, no dump for 100 cycles) -> all outputs 0, state IDLE, SBF never pulses.
2. dump pulse, then TX model sends 32 frames of bytes 0x00..0x1F at CLKS_PER_BIT=8 -> SBF pulses once 1 cycle after dump; byte_count=32; done pulses once; frame_err=0; rd_addr=5 gives rd_data=0x05 one cycle later.
3. Dump where frame 3 (0xA5) has stop bit 0 -> frame_err=1; that byte is discarded; byte_count stops at 31 and the run ends by timeout (timeout=1, done pulse).
4. 3-cycle low glitch on SD in WAIT_START, then valid frame 0xD5 -> glitch rejected; mem[0]=0xD5; byte_count=1.
5. dump, SD held high for 4096 cycles -> timeout=1, done pulse, busy=0, byte_count=0. A second dump pulse during busy -> ignored, no second SBF.
6. reset asserted mid-frame at byte 10 bit 4 -> next cycle all outputs at reset values. A new dump afterwards completes normally with byte_count=32.
